// File: rtl/layer_seq_ctrl.sv
// ============================================================================
// Module   : layer_seq_ctrl
// Function : Snapshots NN parallel neuron outputs and replays them as a
//            valid/ready serial stream for the next fully-connected layer.
//            Optional running signed argmax: define LAYER_SEQ_MAXSEL_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_seq_ctrl #(
  parameter int unsigned NN        = 30,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned cntWidth  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           i_valid,
  input  logic [NN*dataWidth-1:0] i_data,
  input  logic                    i_ready,
  output logic                    o_valid,
  output logic [dataWidth-1:0]    o_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_overrun,
  output logic [cntWidth-1:0]     o_max_idx,
  output logic                    o_max_valid
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_e;

  localparam logic [cntWidth-1:0] LAST_IDX = cntWidth'(NN - 1);

  state_e                state_q, state_d;
  logic [cntWidth-1:0]   cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic                  overrun_q, overrun_d;
  logic [dataWidth-1:0]  snap_q [NN];

  logic all_valid;
  logic capture;
  logic xfer;
  logic last;

  assign all_valid = &i_valid;
  assign capture   = (state_q == S_IDLE) && all_valid;
  assign xfer      = (state_q == S_SEND) && i_ready;
  assign last      = (cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    case (state_q)
      S_IDLE: begin
        if (all_valid) begin
          state_d = S_SEND;
          cnt_d   = '0;
        end
      end
      S_SEND: begin
        // A full snapshot arriving mid-stream is dropped, not queued.
        if (all_valid) overrun_d = 1'b1;
        if (xfer) begin
          if (last) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NN; n++) snap_q[n] <= '0;
    end else if (capture) begin
      for (int n = 0; n < NN; n++) snap_q[n] <= i_data[n*dataWidth +: dataWidth];
    end
  end

  assign o_valid   = (state_q == S_SEND);
  assign o_busy    = (state_q == S_SEND);
  assign o_data    = (state_q == S_SEND) ? snap_q[cnt_q] : '0;
  assign o_done    = done_q;
  assign o_overrun = overrun_q;

`ifdef LAYER_SEQ_MAXSEL_EN
  localparam logic signed [dataWidth-1:0] MIN_VAL = {1'b1, {(dataWidth-1){1'b0}}};

  logic signed [dataWidth-1:0] max_val_q;
  logic [cntWidth-1:0]         run_idx_q;
  logic [cntWidth-1:0]         max_idx_q;
  logic                        max_valid_q;
  logic signed [dataWidth-1:0] elem;
  logic                        gt;
  logic [cntWidth-1:0]         new_idx;

  // Strict compare keeps the lowest index on ties.
  assign elem    = $signed(snap_q[cnt_q]);
  assign gt      = (elem > max_val_q);
  assign new_idx = gt ? cnt_q : run_idx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_val_q   <= MIN_VAL;
      run_idx_q   <= '0;
      max_idx_q   <= '0;
      max_valid_q <= 1'b0;
    end else begin
      max_valid_q <= 1'b0;
      if (capture) begin
        max_val_q <= MIN_VAL;
        run_idx_q <= '0;
        max_idx_q <= '0;
      end else if (xfer) begin
        if (gt) begin
          max_val_q <= elem;
          run_idx_q <= cnt_q;
        end
        if (last) begin
          max_idx_q   <= new_idx;
          max_valid_q <= 1'b1;
        end
      end
    end
  end

  assign o_max_idx   = max_idx_q;
  assign o_max_valid = max_valid_q;
`else
  assign o_max_idx   = '0;
  assign o_max_valid = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl with NN=4, dataWidth=16, cntWidth=2.
`default_nettype none

module tb_layer_seq_ctrl;

  localparam int NN = 4;
  localparam int DW = 16;
  localparam int CW = 2;

  logic              clk;
  logic              rst;
  logic [NN-1:0]     i_valid;
  logic [NN*DW-1:0]  i_data;
  logic              i_ready;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic              o_busy;
  logic              o_done;
  logic              o_overrun;
  logic [CW-1:0]     o_max_idx;
  logic              o_max_valid;

  int checks   = 0;
  int failures = 0;

  layer_seq_ctrl #(.NN(NN), .dataWidth(DW), .cntWidth(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overrun  (o_overrun),
    .o_max_idx  (o_max_idx),
    .o_max_valid(o_max_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NN-1:0]    valid;
    logic             ready;
    logic [NN*DW-1:0] din;
    logic             ev;
    logic [DW-1:0]    ed;
    logic             eb;
    logic             edn;
    logic             eov;
  } vec_t;

  vec_t tbl[$];

`ifdef LAYER_SEQ_MAXSEL_EN
  localparam logic [CW-1:0] EXP_MAX_IDX = 2'd1;
  localparam logic          EXP_MAX_V   = 1'b1;
`else
  localparam logic [CW-1:0] EXP_MAX_IDX = 2'd0;
  localparam logic          EXP_MAX_V   = 1'b0;
`endif

  function automatic vec_t mk(input logic [NN-1:0] v, input logic r, input logic [NN*DW-1:0] d,
                              input logic ev, input logic [DW-1:0] ed, input logic eb,
                              input logic edn, input logic eov);
    vec_t t;
    t.valid = v; t.ready = r; t.din = d;
    t.ev = ev; t.ed = ed; t.eb = eb; t.edn = edn; t.eov = eov;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [NN*DW-1:0] D1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [NN*DW-1:0] D2 = {16'd40, 16'd30, 16'd20, 16'd10};
  localparam logic [NN*DW-1:0] D3 = {16'd8, 16'd7, 16'd6, 16'd5};
  localparam logic [NN*DW-1:0] DM = {16'h8000, 16'h0007, 16'h0007, 16'hFFFB};

  initial begin
    logic [DW-1:0] mexp [NN];
    mexp[0] = 16'hFFFB; mexp[1] = 16'h0007; mexp[2] = 16'h0007; mexp[3] = 16'h8000;

    rst = 1'b0; i_valid = '0; i_data = '0; i_ready = 1'b1;

    // Stall-free stream, back-to-back order
    tbl.push_back(mk(4'hF, 1, D1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 3, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 4, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(4'h0, 1, D1, 0, 0, 0, 0, 0));
    // Back-pressure on the 2nd and 3rd values
    tbl.push_back(mk(4'hF, 1, D1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, D1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 2, 1, 0, 0));
    tbl.push_back(mk(4'h0, 0, D1, 1, 3, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 3, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 4, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(4'h0, 1, D1, 0, 0, 0, 0, 0));
    // Partial valid ignored
    tbl.push_back(mk(4'h7, 1, D2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h7, 1, D2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h7, 1, D2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 1, D2, 0, 0, 0, 0, 0));
    // Overrun during stream, then capture in the done cycle
    tbl.push_back(mk(4'hF, 1, D1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(4'h0, 1, D1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(4'hF, 1, D2, 1, 2, 1, 0, 0));
    tbl.push_back(mk(4'h0, 1, D2, 1, 3, 1, 0, 1));
    tbl.push_back(mk(4'h0, 1, D2, 1, 4, 1, 0, 1));
    tbl.push_back(mk(4'hF, 1, D3, 0, 0, 0, 1, 1));
    tbl.push_back(mk(4'h0, 1, D3, 1, 5, 1, 0, 1));
    tbl.push_back(mk(4'h0, 1, D3, 1, 6, 1, 0, 1));
    tbl.push_back(mk(4'h0, 1, D3, 1, 7, 1, 0, 1));
    tbl.push_back(mk(4'h0, 1, D3, 1, 8, 1, 0, 1));
    tbl.push_back(mk(4'h0, 1, D3, 0, 0, 0, 1, 1));

    step(); step();
    chk("rst_valid",   32'(o_valid), 0);
    chk("rst_data",    32'(o_data), 0);
    chk("rst_busy",    32'(o_busy), 0);
    chk("rst_done",    32'(o_done), 0);
    chk("rst_overrun", 32'(o_overrun), 0);
    chk("rst_max_idx", 32'(o_max_idx), 0);
    chk("rst_max_v",   32'(o_max_valid), 0);
    rst = 1'b1;
    step();

    for (int i = 0; i < tbl.size(); i++) begin
      i_valid = tbl[i].valid;
      i_ready = tbl[i].ready;
      i_data  = tbl[i].din;
      chk($sformatf("row%0d_valid", i),   32'(o_valid),   32'(tbl[i].ev));
      chk($sformatf("row%0d_data", i),    32'(o_data),    32'(tbl[i].ed));
      chk($sformatf("row%0d_busy", i),    32'(o_busy),    32'(tbl[i].eb));
      chk($sformatf("row%0d_done", i),    32'(o_done),    32'(tbl[i].edn));
      chk($sformatf("row%0d_overrun", i), 32'(o_overrun), 32'(tbl[i].eov));
      step();
    end

    // Asynchronous reset in the middle of a stream
    i_ready = 1'b1; i_data = D1; i_valid = 4'hF;
    step();
    i_valid = '0;
    chk("mid_d0", 32'(o_data), 1);
    step();
    chk("mid_d1", 32'(o_data), 2);
    step();
    chk("mid_d2", 32'(o_data), 3);
    rst = 1'b0;
    #1;
    chk("arst_valid",   32'(o_valid), 0);
    chk("arst_data",    32'(o_data), 0);
    chk("arst_busy",    32'(o_busy), 0);
    chk("arst_done",    32'(o_done), 0);
    chk("arst_overrun", 32'(o_overrun), 0);
    step();
    rst = 1'b1;
    i_data = D3; i_valid = 4'hF;
    step();
    i_valid = '0;
    chk("post_rst_d0",   32'(o_data), 5);
    chk("post_rst_busy", 32'(o_busy), 1);
    step(); step(); step();
    chk("post_rst_d3",   32'(o_data), 8);
    step();
    chk("post_rst_done", 32'(o_done), 1);
    step();

    // Signed argmax with a tie and the most negative value
    i_data = DM; i_valid = 4'hF;
    step();
    i_valid = '0;
    for (int i = 0; i < NN; i++) begin
      chk($sformatf("max_stream%0d", i), 32'(o_data), 32'(mexp[i]));
      chk($sformatf("max_v_early%0d", i), 32'(o_max_valid), 0);
      step();
    end
    chk("max_done",  32'(o_done), 1);
    chk("max_valid", 32'(o_max_valid), 32'(EXP_MAX_V));
    chk("max_idx",   32'(o_max_idx), 32'(EXP_MAX_IDX));
    step();
    chk("max_valid_pulse", 32'(o_max_valid), 0);
    chk("max_idx_hold",    32'(o_max_idx), 32'(EXP_MAX_IDX));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
